// File: rtl/loop_controller_if.sv
// loop_controller_if: decoder-to-loop-sequencer command bus and pc-side results.
// all_iteration_indices exists only when LOOP_CONTROLLER_ALL_INDICES_EN is defined.
interface loop_controller_if #(
    parameter int MAX_DEPTH = 4,
    parameter int ITER_WIDTH = 16,
    parameter int INSTRUCTION_ADDR_WIDTH = 18
);
    logic                              loop_start;
    logic                              loop_end;
    logic [ITER_WIDTH-1:0]             loop_iterations;
    logic [INSTRUCTION_ADDR_WIDTH-1:0] loop_start_pc;
    logic                              jump;
    logic [INSTRUCTION_ADDR_WIDTH-1:0] jump_target;
    logic [2:0]                        depth;
    logic [ITER_WIDTH-1:0]             iteration_index;
    logic                              error;
    logic [1:0]                        error_code;
`ifdef LOOP_CONTROLLER_ALL_INDICES_EN
    logic [MAX_DEPTH*ITER_WIDTH-1:0]   all_iteration_indices;
`endif

    modport master (
        output loop_start, loop_end, loop_iterations, loop_start_pc,
`ifdef LOOP_CONTROLLER_ALL_INDICES_EN
        input all_iteration_indices,
`endif
        input jump, jump_target, depth, iteration_index, error, error_code
    );

    modport slave (
        input loop_start, loop_end, loop_iterations, loop_start_pc,
`ifdef LOOP_CONTROLLER_ALL_INDICES_EN
        output all_iteration_indices,
`endif
        output jump, jump_target, depth, iteration_index, error, error_code
    );
endinterface

// File: rtl/loop_controller.sv
// loop_controller: hardware loop sequencer with a nesting stack of trip counters and body addresses.
// Optional per-level index export under LOOP_CONTROLLER_ALL_INDICES_EN.
module loop_controller #(
    parameter int MAX_DEPTH = 4,
    parameter int ITER_WIDTH = 16,
    parameter int INSTRUCTION_ADDR_WIDTH = 18
) (
    input logic clk,
    input logic reset,
    loop_controller_if.slave bus
);
    localparam int AW = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;
    localparam logic [2:0] MAXD = 3'(MAX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t state, state_n;
    logic [ITER_WIDTH-1:0] rem [MAX_DEPTH];
    logic [ITER_WIDTH-1:0] idx [MAX_DEPTH];
    logic [INSTRUCTION_ADDR_WIDTH-1:0] spc [MAX_DEPTH];
    logic [2:0] depth;
    logic [AW-1:0] top;
    logic push, take, pop, err_n;
    logic [1:0] code_n;
    logic jump, error;
    logic [1:0] error_code;

    assign top = AW'(depth - 3'd1);

    always_comb begin
        state_n = state;
        push = 1'b0;
        take = 1'b0;
        pop = 1'b0;
        err_n = 1'b0;
        code_n = 2'b00;
        if (state != S_ERROR) begin
            if (bus.loop_start && bus.loop_end) begin
                err_n = 1'b1;
                code_n = 2'b11;
            end else if (bus.loop_start) begin
                err_n = depth == MAXD || bus.loop_iterations == '0;
                code_n = depth == MAXD ? 2'b01 : 2'b11;
                push = !err_n;
            end else if (bus.loop_end) begin
                err_n = depth == 3'd0;
                code_n = 2'b10;
                take = !err_n && rem[top] != '0;
                pop = !err_n && rem[top] == '0;
            end
            state_n = err_n ? S_ERROR
                    : (push || (depth != 3'd0 && !(pop && depth == 3'd1))) ? S_ACTIVE : S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            jump <= 1'b0;
            error <= 1'b0;
            error_code <= 2'b00;
        end else begin
            state <= state_n;
            jump <= take;
            if (err_n) begin
                error <= 1'b1;
                error_code <= code_n;
            end
        end
    end

    // Popped levels are zeroed so unused stack slots always read back as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= 3'd0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                rem[i] <= '0;
                idx[i] <= '0;
                spc[i] <= '0;
            end
        end else if (push) begin
            rem[AW'(depth)] <= bus.loop_iterations - ITER_WIDTH'(1);
            idx[AW'(depth)] <= '0;
            spc[AW'(depth)] <= bus.loop_start_pc;
            depth <= depth + 3'd1;
        end else if (take) begin
            rem[top] <= rem[top] - ITER_WIDTH'(1);
            idx[top] <= idx[top] + ITER_WIDTH'(1);
        end else if (pop) begin
            rem[top] <= '0;
            idx[top] <= '0;
            spc[top] <= '0;
            depth <= depth - 3'd1;
        end
    end

    assign bus.jump = jump;
    assign bus.error = error;
    assign bus.error_code = error_code;
    assign bus.depth = depth;
    assign bus.jump_target = depth == 3'd0 ? '0 : spc[top];
    assign bus.iteration_index = depth == 3'd0 ? '0 : idx[top];

`ifdef LOOP_CONTROLLER_ALL_INDICES_EN
    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_idx
        assign bus.all_iteration_indices[k*ITER_WIDTH +: ITER_WIDTH] = idx[k];
    end
`endif
endmodule

// File: tb/tb_loop_controller.sv
// tb_loop_controller: directed stimulus against a queue-based loop-stack model,
// compared on every falling edge, plus literal expectations at key points.
module tb_loop_controller;
    localparam int MD = 4;
    localparam int IW = 16;
    localparam int AWD = 18;

    typedef struct {int rem; int idx; int pc;} ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int passes = 0;
    ent_t st[$];
    bit m_jump, m_err;
    int m_code;

    loop_controller_if #(.MAX_DEPTH(MD), .ITER_WIDTH(IW), .INSTRUCTION_ADDR_WIDTH(AWD)) bus ();
    loop_controller #(.MAX_DEPTH(MD), .ITER_WIDTH(IW), .INSTRUCTION_ADDR_WIDTH(AWD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        st.delete();
        m_jump = 0;
        m_err = 0;
        m_code = 0;
    endfunction

    function automatic void model_apply(input bit s, input bit e, input int n, input int pc);
        m_jump = 0;
        if (m_err) return;
        if (s && e) begin m_err = 1; m_code = 3; end
        else if (s) begin
            if (st.size() == MD) begin m_err = 1; m_code = 1; end
            else if (n == 0) begin m_err = 1; m_code = 3; end
            else st.push_back('{n - 1, 0, pc});
        end else if (e) begin
            if (st.size() == 0) begin m_err = 1; m_code = 2; end
            else if (st[st.size()-1].rem > 0) begin
                st[st.size()-1].rem--;
                st[st.size()-1].idx++;
                m_jump = 1;
            end else void'(st.pop_back());
        end
    endfunction

    always @(negedge clk) begin
        int d;
        d = st.size();
        chk("depth", 64'(bus.depth), 64'(d));
        chk("jump", 64'(bus.jump), 64'(m_jump));
        chk("jump_target", 64'(bus.jump_target), d == 0 ? 64'd0 : 64'(st[d-1].pc));
        chk("iteration_index", 64'(bus.iteration_index), d == 0 ? 64'd0 : 64'(st[d-1].idx));
        chk("error", 64'(bus.error), 64'(m_err));
        chk("error_code", 64'(bus.error_code), 64'(m_code));
`ifdef LOOP_CONTROLLER_ALL_INDICES_EN
        for (int k = 0; k < MD; k++)
            chk("all_idx_slice", 64'(bus.all_iteration_indices[k*IW +: IW]), k < d ? 64'(st[k].idx) : 64'd0);
`endif
    end

    // One clock cycle with the given command; inputs return to idle afterwards.
    task automatic step(input bit s, input bit e, input int n = 0, input int pc = 0);
        bus.loop_start = s;
        bus.loop_end = e;
        bus.loop_iterations = IW'(n);
        bus.loop_start_pc = AWD'(pc);
        @(posedge clk);
        #1;
        model_apply(s, e, n, pc);
        bus.loop_start = 0;
        bus.loop_end = 0;
        bus.loop_iterations = '0;
        bus.loop_start_pc = '0;
    endtask

    task automatic do_reset();
        #1 reset = 1;
        model_reset();
        #1 reset = 0;
    endtask

    initial begin
        model_reset();
        bus.loop_start = 0;
        bus.loop_end = 0;
        bus.loop_iterations = '0;
        bus.loop_start_pc = '0;
        #1;
        chk("rst_depth", 64'(bus.depth), 64'd0);
        chk("rst_jump", 64'(bus.jump), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        #1 reset = 0;

        // single loop N=3
        step(1, 0, 3, 'h10);
        chk("l1_depth", 64'(bus.depth), 64'd1);
        step(0, 1);
        chk("l1_jump1", 64'(bus.jump), 64'd1);
        chk("l1_target1", 64'(bus.jump_target), 64'h10);
        chk("l1_idx1", 64'(bus.iteration_index), 64'd1);
        step(0, 0);
        chk("l1_jump_drop", 64'(bus.jump), 64'd0);
        step(0, 1);
        chk("l1_idx2", 64'(bus.iteration_index), 64'd2);
        step(0, 1);
        chk("l1_nojump", 64'(bus.jump), 64'd0);
        chk("l1_depth0", 64'(bus.depth), 64'd0);
        step(0, 0);

        // nested 2x2
        step(1, 0, 2, 'h20);
        step(1, 0, 2, 'h30);
        step(0, 1);
        chk("n_target1", 64'(bus.jump_target), 64'h30);
        step(0, 1);
        chk("n_pop_depth", 64'(bus.depth), 64'd1);
        step(0, 1);
        chk("n_target2", 64'(bus.jump_target), 64'h20);
        chk("n_jump2", 64'(bus.jump), 64'd1);
        step(1, 0, 2, 'h30);
        step(0, 1);
        chk("n_target3", 64'(bus.jump_target), 64'h30);
        step(0, 1);
        chk("n_idx_back1", 64'(bus.iteration_index), 64'd1);
        step(0, 1);
        chk("n_final_depth", 64'(bus.depth), 64'd0);

        // overflow
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 5, 'h100 + i);
        step(1, 0, 5, 'h200);
        chk("ovf_error", 64'(bus.error), 64'd1);
        chk("ovf_code", 64'(bus.error_code), 64'd1);
        chk("ovf_depth", 64'(bus.depth), 64'd4);
        step(0, 1);
        chk("ovf_end_ignored", 64'(bus.jump), 64'd0);
        step(0, 0);

        // underflow, zero trip, simultaneous, max trip count
        do_reset();
        step(0, 1);
        chk("unf_code", 64'(bus.error_code), 64'd2);
        step(1, 0, 1, 'h5);
        do_reset();
        step(1, 0, 0, 'h5);
        chk("zero_code", 64'(bus.error_code), 64'd3);
        chk("zero_depth", 64'(bus.depth), 64'd0);
        do_reset();
        step(1, 1, 2, 'h5);
        chk("sim_code", 64'(bus.error_code), 64'd3);
        do_reset();
        step(1, 0, 65535, 'h3ffff);
        step(0, 1);
        chk("max_jump", 64'(bus.jump), 64'd1);
        chk("max_target", 64'(bus.jump_target), 64'h3ffff);
        step(0, 0);

        // async reset mid-loop while jump is high
        do_reset();
        step(1, 0, 2, 'h40);
        step(1, 0, 2, 'h50);
        step(0, 1);
        chk("ar_pre_jump", 64'(bus.jump), 64'd1);
        #1 reset = 1;
        model_reset();
        #1;
        chk("ar_jump", 64'(bus.jump), 64'd0);
        chk("ar_depth", 64'(bus.depth), 64'd0);
        chk("ar_target", 64'(bus.jump_target), 64'd0);
        chk("ar_idx", 64'(bus.iteration_index), 64'd0);
        #1 reset = 0;
        step(1, 0, 1, 'h60);
        chk("ar_depth1", 64'(bus.depth), 64'd1);
        step(0, 1);
        chk("ar_nojump", 64'(bus.jump), 64'd0);
        chk("ar_depth0", 64'(bus.depth), 64'd0);
        step(0, 0);

`ifdef LOOP_CONTROLLER_ALL_INDICES_EN
        do_reset();
        step(1, 0, 3, 'h70);
        step(1, 0, 2, 'h80);
        step(0, 1);
        step(0, 1);
        step(0, 1);
        chk("all_slice0", 64'(bus.all_iteration_indices[0 +: IW]), 64'd1);
        chk("all_slice1", 64'(bus.all_iteration_indices[IW +: IW]), 64'd0);
        step(0, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/loop_controller.md
Name: loop_controller

Overview:
- Hardware loop sequencer for the Cherry control unit; consumes decoded loop instructions (start_loop / end_loop) and tells the PC logic when to jump back to a loop body.
- Holds a nesting stack of iteration counters and body start addresses.
- Exposes the innermost iteration index to the APU instruction path.
- Sits between the decoder's loop_instruction output and the pc register.

Parameters:
MAX_DEPTH, 4, maximum loop nesting levels held in the stack
ITER_WIDTH, 16, width of iteration count and iteration index
INSTRUCTION_ADDR_WIDTH, 18, width of pc / jump target

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
loop_start  input  1  start_loop instruction valid this cycle
loop_end  input  1  end_loop instruction valid this cycle
loop_iterations  input  ITER_WIDTH  total trip count for loop_start
loop_start_pc  input  INSTRUCTION_ADDR_WIDTH  address of first body instruction for loop_start
jump  output  1  registered one-cycle pulse: pc must load jump_target
jump_target  output  INSTRUCTION_ADDR_WIDTH  body start address of innermost loop
depth  output  3  current nesting depth, 0..MAX_DEPTH
iteration_index  output  ITER_WIDTH  innermost loop's current iteration, 0-based
error  output  1  sticky fault flag
error_code  output  2  01 overflow, 10 underflow, 11 zero-trip or simultaneous command

Behaviour:
- Reset (async, any time, including mid-loop): state IDLE, depth=0, jump=0, jump_target=0, iteration_index=0, error=0, error_code=00, all stack entries cleared.
- States:
  - IDLE: depth==0.
  - ACTIVE: depth>=1.
  - ERROR: terminal until reset.
- Each stack entry holds remaining[ITER_WIDTH], index[ITER_WIDTH] and start_pc.
- loop_start with loop_iterations=N>=1 and depth<MAX_DEPTH:
  - Push {remaining=N-1, index=0, start_pc}; depth+1.
  - iteration_index=0 next cycle; IDLE->ACTIVE if depth was 0.
- loop_end with depth>=1:
  - If innermost remaining!=0: next cycle jump=1, jump_target=innermost start_pc, remaining-1, index+1.
  - If remaining==0: pop, depth-1, jump=0, iteration_index shows the new innermost entry's index (0 if depth becomes 0); ACTIVE->IDLE when depth reaches 0.
- Latency: every output is registered, one cycle after the command.
- jump is high for exactly one cycle per taken back-edge and deasserts the following cycle unless another taken loop_end arrives.
- jump_target always reflects the innermost start_pc, or 0 when depth=0.
- Errors: no stack change; error=1, error_code set, state->ERROR.
  - loop_start at depth==MAX_DEPTH: code 01.
  - loop_end at depth==0: code 10.
  - loop_iterations==0: code 11.
  - loop_start and loop_end in the same cycle: code 11.
- In ERROR, all commands are ignored; jump=0; outputs hold until reset.
- Arithmetic: remaining and index use ITER_WIDTH unsigned.
  - index never wraps, since index + remaining == N-1 always holds.
  - N=2^ITER_WIDTH-1 is legal.
- depth counter is 3 bits and never exceeds MAX_DEPTH.

Optional Feature:
- Macro: LOOP_CONTROLLER_ALL_INDICES_EN.
- When defined, add output all_iteration_indices [MAX_DEPTH*ITER_WIDTH-1:0].
  - Slice k holds the index of stack level k (level 0 = outermost).
  - Unused levels read 0.
  - Updated on the same cycle as iteration_index.
- When undefined: the port does not exist, and per-level index registers for non-innermost levels are still kept (needed on pop) but not exported.

Test Plan:
- Reset, loop_start N=3 pc=0x10, then 3x loop_end:
  - jump pulses with target 0x10 after the 1st and 2nd loop_end.
  - No jump after the 3rd; iteration_index 0,1,2; depth 1->0.
- Nested: start N=2 pc=0x20, start N=2 pc=0x30, end,end,end,end,end,end in program order:
  - jump targets 0x30, 0x20, 0x30.
  - iteration_index returns to 1 after the inner pop; final depth=0.
- Push 4 loops, then a 5th loop_start -> error=1, error_code=01, depth stays 4, subsequent loop_end ignored.
- loop_end at depth=0 -> error_code=10; loop_start N=0 after reset -> error_code=11, depth=0.
- Assert reset mid-loop (depth=2, jump=1 cycle) -> all outputs 0 asynchronously; fresh loop_start N=1 then loop_end -> no jump, depth 1->0.
- With LOOP_CONTROLLER_ALL_INDICES_EN: nested N=3/N=2, after 3 loop_ends (inner, inner pop, outer jump) -> slice0=1, slice1=0.
